// File: rtl/conv1_scheduler.sv
// Conv1 layer sequencer: fetches per-filter weights, streams input pairs and
// writes ReLU/shift/saturated results filter-major into the layer-1 output RAM.
module conv1_scheduler #(
  parameter int unsigned NUM_FILTERS = 20,
  parameter int unsigned IN_LEN      = 64,
  parameter int unsigned XAW         = 6,
  parameter int unsigned YAW         = 11,
  parameter int unsigned SHIFT       = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  w_start,
  output logic [4:0]            w_filter,
  input  logic signed [15:0]    w0,
  input  logic signed [15:0]    w1,
  input  logic signed [31:0]    b,
  input  logic                  w_done,
  output logic                  x_rd,
  output logic [XAW-1:0]        x_addr,
  input  logic signed [15:0]    x_data,
  output logic                  y_we,
  output logic [YAW-1:0]        y_addr,
  output logic [15:0]           y_data
);

  localparam int unsigned OUT_LEN = IN_LEN - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADW, S_RD0, S_RD1, S_CALC, S_WR, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            f_q, f_d;
  logic [XAW-1:0]        i_q, i_d;
  logic [YAW-1:0]        ya_q, ya_d;
  logic signed [15:0]    w0_q, w0_d, w1_q, w1_d, x0_q, x0_d;
  logic signed [31:0]    b_q, b_d;
  logic                  busy_q, busy_d, done_q, done_d, w_start_q, w_start_d;
  logic                  x_rd_q, x_rd_d, y_we_q, y_we_d;
  logic [4:0]            w_filter_q, w_filter_d;
  logic [XAW-1:0]        x_addr_q, x_addr_d;
  logic [YAW-1:0]        y_addr_q, y_addr_d;
  logic [15:0]           y_data_q, y_data_d;
  logic signed [31:0]    prod0, prod1;
  logic signed [33:0]    acc, shifted;
  logic [15:0]           sat_val;

  // Datapath: second sample is taken straight from the RAM port in CALC
  always_comb begin
    prod0   = x0_q * w0_q;
    prod1   = x_data * w1_q;
    acc     = 34'(prod0) + 34'(prod1) + 34'(b_q);
    shifted = acc >>> SHIFT;
    if (acc[33]) begin
      sat_val = '0;
    end else if (shifted > 34'sd32767) begin
      sat_val = 16'h7fff;
    end else begin
      sat_val = shifted[15:0];
    end
  end

  // Next-state and registered-output decode (outputs follow the next state)
  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    i_d        = i_q;
    ya_d       = ya_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    b_d        = b_q;
    x0_d       = x0_q;
    x_addr_d   = x_addr_q;
    y_addr_d   = y_addr_q;
    y_data_d   = y_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADW;
          f_d     = '0;
          i_d     = '0;
          ya_d    = '0;
        end
      end
      S_LOADW: begin
        if (w_done) begin
          w0_d    = w0;
          w1_d    = w1;
          b_d     = b;
          state_d = S_RD0;
        end
      end
      S_RD0:  state_d = S_RD1;
      S_RD1: begin
        x0_d    = x_data;
        state_d = S_CALC;
      end
      S_CALC: state_d = S_WR;
      S_WR: begin
        ya_d = ya_q + YAW'(1);
        if (i_q < XAW'(OUT_LEN - 1)) begin
          i_d     = i_q + XAW'(1);
          state_d = S_RD0;
        end else if (f_q < 5'(NUM_FILTERS - 1)) begin
          f_d     = f_q + 5'(1);
          i_d     = '0;
          state_d = S_LOADW;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_LOADW) || (state_d == S_RD0) || (state_d == S_RD1) ||
                 (state_d == S_CALC)  || (state_d == S_WR);
    done_d     = (state_d == S_DONE);
    w_start_d  = (state_d == S_LOADW);
    w_filter_d = f_d;
    x_rd_d     = (state_d == S_RD0) || (state_d == S_RD1);
    y_we_d     = (state_d == S_WR);
    if (state_d == S_RD0) x_addr_d = i_d;
    if (state_d == S_RD1) x_addr_d = i_q + XAW'(1);
    if (state_d == S_WR) begin
      y_addr_d = ya_q;
      y_data_d = sat_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      f_q        <= '0;
      i_q        <= '0;
      ya_q       <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      b_q        <= '0;
      x0_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_start_q  <= 1'b0;
      w_filter_q <= '0;
      x_rd_q     <= 1'b0;
      x_addr_q   <= '0;
      y_we_q     <= 1'b0;
      y_addr_q   <= '0;
      y_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      i_q        <= i_d;
      ya_q       <= ya_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      b_q        <= b_d;
      x0_q       <= x0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      w_start_q  <= w_start_d;
      w_filter_q <= w_filter_d;
      x_rd_q     <= x_rd_d;
      x_addr_q   <= x_addr_d;
      y_we_q     <= y_we_d;
      y_addr_q   <= y_addr_d;
      y_data_q   <= y_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign w_start  = w_start_q;
  assign w_filter = w_filter_q;
  assign x_rd     = x_rd_q;
  assign x_addr   = x_addr_q;
  assign y_we     = y_we_q;
  assign y_addr   = y_addr_q;
  assign y_data   = y_data_q;

endmodule
